// File: rtl/pid_ctrl_pipe.sv
// Purpose : pipelined PID steering controller; signed heading error + forward speed -> saturated L/R motor speeds.
// Latency : stage-1 registers on the err_vld edge, outputs + spd_vld on the following edge; 1 result/cycle.
// Backpressure: none (no ready); outputs hold between updates, moving=0 flushes the pipe and zeroes outputs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   moving              control enable; low clears all state and forces zero speeds
//   err_vld, error      signed error sample and its valid
//   frwrd               unsigned forward speed
//   p_coeff, d_coeff    runtime P / D gains (unsigned)
//   i_mode              integrator overflow policy: 0 = hold, 1 = clamp to rail
//   clr_integ           synchronous integrator (and integ_sat) clear
//   lft_spd, rght_spd   saturated signed motor speeds
//   spd_vld             one-cycle strobe when speeds update
//   integ_sat           sticky integrator-overflow flag
module pid_ctrl_pipe #(
    parameter int ERR_W     = 12,
    parameter int SAT_W     = 10,
    parameter int SPD_W     = 11,
    parameter int I_W       = 15,
    parameter int I_SHIFT   = 6,
    parameter int D_DIFF_W  = 7,
    parameter int D_DEPTH   = 2,
    parameter int PID_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic [ERR_W-1:0]        error,
    input  logic [SPD_W-2:0]        frwrd,
    input  logic [4:0]              p_coeff,
    input  logic [5:0]              d_coeff,
    input  logic                    i_mode,
    input  logic                    clr_integ,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    spd_vld,
    output logic                    integ_sat
);

    // P product: SAT_W signed x 5-bit unsigned (as 6-bit signed)
    localparam int P_W = SAT_W + 6;
    // D product: D_DIFF_W signed x 6-bit unsigned (as 7-bit signed)
    localparam int D_W = D_DIFF_W + 7;
    localparam int S_W = SAT_W + 6;
    // Mixing width wide enough that frwrd +/- s never wraps before saturation
    localparam int M_W = ((S_W > SPD_W) ? S_W : SPD_W) + 2;

    localparam logic signed [ERR_W-1:0]   E_HI  = ERR_W'(2**(SAT_W-1) - 1);
    localparam logic signed [ERR_W-1:0]   E_LO  = ERR_W'(-(2**(SAT_W-1)));
    localparam logic signed [SAT_W:0]     DF_HI = (SAT_W+1)'(2**(D_DIFF_W-1) - 1);
    localparam logic signed [SAT_W:0]     DF_LO = (SAT_W+1)'(-(2**(D_DIFF_W-1)));
    localparam logic signed [M_W-1:0]     O_HI  = M_W'(2**(SPD_W-1) - 1);
    localparam logic signed [M_W-1:0]     O_LO  = M_W'(-(2**(SPD_W-1)));
    localparam logic signed [I_W-1:0]     I_MAX = {1'b0, {(I_W-1){1'b1}}};
    localparam logic signed [I_W-1:0]     I_MIN = {1'b1, {(I_W-1){1'b0}}};

    // ---------------- stage-1 combinational ----------------
    logic signed [SAT_W-1:0]    err_sat;
    logic signed [P_W-1:0]      p_prod;
    logic signed [I_W:0]        acc;
    logic                       ovf;
    logic signed [I_W-1:0]      integ;
    logic signed [I_W-1:0]      integ_nxt;
    logic signed [I_W-1:0]      i_term;
    logic signed [SAT_W:0]      d_full;
    logic signed [D_DIFF_W-1:0] d_sat;
    logic signed [D_W-1:0]      d_prod;
    logic signed [SAT_W-1:0]    hist [D_DEPTH];

    always_comb begin
        if ($signed(error) > E_HI)
            err_sat = E_HI[SAT_W-1:0];
        else if ($signed(error) < E_LO)
            err_sat = E_LO[SAT_W-1:0];
        else
            err_sat = error[SAT_W-1:0];
    end

    assign p_prod = P_W'(err_sat) * P_W'($signed({1'b0, p_coeff}));

    // One guard bit: overflow shows as the top two bits disagreeing
    assign acc = (I_W+1)'(integ) + (I_W+1)'(err_sat);
    assign ovf = acc[I_W] ^ acc[I_W-1];

    always_comb begin
        if (clr_integ)
            integ_nxt = '0;
        else if (ovf)
            integ_nxt = i_mode ? (acc[I_W] ? I_MIN : I_MAX) : integ;
        else
            integ_nxt = acc[I_W-1:0];
    end

    // I term follows the post-update integrator, so a clear zeroes it the same cycle
    assign i_term = integ_nxt >>> I_SHIFT;

    assign d_full = (SAT_W+1)'(err_sat) - (SAT_W+1)'(hist[D_DEPTH-1]);

    always_comb begin
        if (d_full > DF_HI)
            d_sat = DF_HI[D_DIFF_W-1:0];
        else if (d_full < DF_LO)
            d_sat = DF_LO[D_DIFF_W-1:0];
        else
            d_sat = d_full[D_DIFF_W-1:0];
    end

    assign d_prod = D_W'(d_sat) * D_W'($signed({1'b0, d_coeff}));

    // ---------------- stage-1 registers ----------------
    logic signed [P_W-1:0] p_r;
    logic signed [I_W-1:0] i_r;
    logic signed [D_W-1:0] d_r;
    logic                  s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r       <= '0;
            i_r       <= '0;
            d_r       <= '0;
            s1_vld    <= 1'b0;
            integ     <= '0;
            integ_sat <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
        end else if (!moving) begin
            p_r       <= '0;
            i_r       <= '0;
            d_r       <= '0;
            s1_vld    <= 1'b0;
            integ     <= '0;
            integ_sat <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
        end else begin
            s1_vld <= err_vld;
            if (err_vld) begin
                p_r <= p_prod;
                i_r <= i_term;
                d_r <= d_prod;
                for (int k = D_DEPTH-1; k > 0; k--) hist[k] <= hist[k-1];
                hist[0] <= err_sat;
            end
            if (clr_integ)
                integ <= '0;
            else if (err_vld)
                integ <= integ_nxt;
            if (clr_integ)
                integ_sat <= 1'b0;
            else if (err_vld && ovf)
                integ_sat <= 1'b1;
        end
    end

    // ---------------- stage-2 combinational ----------------
    logic signed [S_W-1:0] sum;
    logic signed [S_W-1:0] s_term;
    logic signed [M_W-1:0] fwd_ext;
    logic signed [M_W-1:0] lft_full;
    logic signed [M_W-1:0] rght_full;
    logic signed [SPD_W-1:0] lft_nxt;
    logic signed [SPD_W-1:0] rght_nxt;

    assign sum       = S_W'(p_r) + S_W'(i_r) + S_W'(d_r);
    assign s_term    = sum >>> PID_SHIFT;
    assign fwd_ext   = M_W'($signed({1'b0, frwrd}));
    assign lft_full  = fwd_ext + M_W'(s_term);
    assign rght_full = fwd_ext - M_W'(s_term);

    always_comb begin
        if (lft_full > O_HI)
            lft_nxt = O_HI[SPD_W-1:0];
        else if (lft_full < O_LO)
            lft_nxt = O_LO[SPD_W-1:0];
        else
            lft_nxt = lft_full[SPD_W-1:0];

        if (rght_full > O_HI)
            rght_nxt = O_HI[SPD_W-1:0];
        else if (rght_full < O_LO)
            rght_nxt = O_LO[SPD_W-1:0];
        else
            rght_nxt = rght_full[SPD_W-1:0];
    end

    // ---------------- stage-2 registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else if (!moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= s1_vld;
            if (s1_vld) begin
                lft_spd  <= lft_nxt;
                rght_spd <= rght_nxt;
            end
        end
    end

endmodule
